cascade_timer_ctrl: RTL and testbench

- Run-control sequencer for a two-stage cascaded mod-M timer: low stage mod-M_LO, high stage mod-M_HI.
- Owns the tick prescaler, the start/stop/clear/load FSM, preset loading and alarm compare.
- Sits between the user-facing control logic (buttons, bus registers) and the display/compare logic.
- Replaces free-running counters that have ad-hoc enable and load wiring.

---
 rtl/cascade_timer_pkg.sv | 22 ++
 rtl/cascade_timer_stage.sv | 42 ++++
 rtl/cascade_timer_ctrl.sv | 165 ++++++++++++++++
 tb/tb_cascade_timer_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/cascade_timer_pkg.sv
// Shared definitions for the cascaded mod-M timer: bit-width helper
// and the run-control FSM state encoding.
package cascade_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALARM = 2'd3
    } state_t;

    // Bits needed to hold 'value' (minimum 1).
    function automatic int clogb2(input int value);
        int r;
        r = 1;
        for (int i = 0; i < 31; i++) begin
            if ((value >> i) != 0) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cascade_timer_stage.sv
// One mod-M counter stage. Ports: clk, aclr (async low), clr/load (sync),
// load_data (saturated to M-1), en; q = count, carry = en && q==M-1.
module cascade_timer_stage
    import cascade_timer_pkg::*;
#(
    parameter int M = 60,
    parameter int W = clogb2(M - 1)
) (
    input  logic         clk,
    input  logic         aclr,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         en,
    output logic [W-1:0] q,
    output logic         carry
);

    localparam logic [W-1:0] MAXV = W'(M - 1);

    logic [W-1:0] q_d, q_q;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (load) begin
            q_d = (load_data > MAXV) ? MAXV : load_data;
        end else if (en) begin
            q_d = (q_q == MAXV) ? '0 : q_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) q_q <= '0;
        else       q_q <= q_d;
    end

    assign q     = q_q;
    assign carry = en && (q_q == MAXV);

endmodule

// File: rtl/cascade_timer_ctrl.sv
// Run-control sequencer for a two-stage cascaded timer: prescaler, IDLE/RUN/
// PAUSE/ALARM FSM, preset load and alarm compare. Ports: clk, aclr (async
// low), start/stop/clear/load levels, lo/hi presets and alarm values; outputs
// lo_q/hi_q counts, tick/wrap pulses, running, alarm.
// Optional macro CASCADE_TIMER_AUTO_RELOAD_EN: alarm match reloads the last
// preset, stays in RUN and pulses alarm for one cycle.
module cascade_timer_ctrl
    import cascade_timer_pkg::*;
#(
    parameter  int M_LO     = 60,
    parameter  int M_HI     = 60,
    parameter  int TICK_DIV = 50000000,
    localparam int NL       = clogb2(M_LO - 1),
    localparam int NH       = clogb2(M_HI - 1),
    localparam int PW       = clogb2(TICK_DIV - 1)
) (
    input  logic          clk,
    input  logic          aclr,
    input  logic          start,
    input  logic          stop,
    input  logic          clear,
    input  logic          load,
    input  logic [NL-1:0] lo_data,
    input  logic [NH-1:0] hi_data,
    input  logic [NL-1:0] alarm_lo,
    input  logic [NH-1:0] alarm_hi,
    output logic [NL-1:0] lo_q,
    output logic [NH-1:0] hi_q,
    output logic          tick,
    output logic          wrap,
    output logic          running,
    output logic          alarm
);

    localparam logic [NL-1:0] LO_MAX  = NL'(M_LO - 1);
    localparam logic [NH-1:0] HI_MAX  = NH'(M_HI - 1);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    state_t        state_d, state_q;
    logic [PW-1:0] pre_d, pre_q;
    logic          running_d, running_q;
    logic          alarm_d, alarm_q;

    logic          cnt_clr, cnt_load, load_ok, match;
    logic          lo_carry, hi_carry;
    logic [NL-1:0] lo_nx, ld_lo;
    logic [NH-1:0] hi_nx, ld_hi;

    assign tick = (state_q == ST_RUN) && (pre_q == PRE_MAX);
    assign wrap = hi_carry;

    // Counts the stages will hold after this tick; alarm compares these.
    assign lo_nx = (lo_q == LO_MAX) ? '0 : lo_q + NL'(1);
    assign hi_nx = !lo_carry ? hi_q :
                   (hi_q == HI_MAX) ? '0 : hi_q + NH'(1);
    assign match = tick && !clear &&
                   (lo_nx == alarm_lo) && (hi_nx == alarm_hi);

`ifdef CASCADE_TIMER_AUTO_RELOAD_EN
    logic [NL-1:0] preset_lo_d, preset_lo_q;
    logic [NH-1:0] preset_hi_d, preset_hi_q;

    always_comb begin
        preset_lo_d = preset_lo_q;
        preset_hi_d = preset_hi_q;
        if (load_ok) begin
            preset_lo_d = (lo_data > LO_MAX) ? LO_MAX : lo_data;
            preset_hi_d = (hi_data > HI_MAX) ? HI_MAX : hi_data;
        end
    end

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            preset_lo_q <= '0;
            preset_hi_q <= '0;
        end else begin
            preset_lo_q <= preset_lo_d;
            preset_hi_q <= preset_hi_d;
        end
    end

    // A match overrides the tick increment with the stored preset.
    assign cnt_load = load_ok || match;
    assign ld_lo    = match ? preset_lo_q : lo_data;
    assign ld_hi    = match ? preset_hi_q : hi_data;
`else
    assign cnt_load = load_ok;
    assign ld_lo    = lo_data;
    assign ld_hi    = hi_data;
`endif

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        cnt_clr = 1'b0;
        load_ok = 1'b0;
        if (state_q == ST_RUN) begin
            pre_d = tick ? '0 : pre_q + PW'(1);
        end
        if (clear) begin
            state_d = ST_IDLE;
            pre_d   = '0;
            cnt_clr = 1'b1;
        end else if (state_q == ST_RUN) begin
            if (stop) state_d = ST_PAUSE;
`ifndef CASCADE_TIMER_AUTO_RELOAD_EN
            if (match) state_d = ST_ALARM;
`endif
        end else if (!stop) begin
            if (start) begin
                state_d = ST_RUN;
                if (state_q == ST_IDLE) pre_d = '0;
            end else if (load && state_q != ST_ALARM) begin
                load_ok = 1'b1;
                pre_d   = '0;
            end
        end
        running_d = (state_d == ST_RUN);
`ifdef CASCADE_TIMER_AUTO_RELOAD_EN
        alarm_d = match;
`else
        alarm_d = (state_d == ST_ALARM);
`endif
    end

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            state_q   <= ST_IDLE;
            pre_q     <= '0;
            running_q <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            running_q <= running_d;
            alarm_q   <= alarm_d;
        end
    end

    assign running = running_q;
    assign alarm   = alarm_q;

    cascade_timer_stage #(.M(M_LO), .W(NL)) u_lo (
        .clk       (clk),
        .aclr      (aclr),
        .clr       (cnt_clr),
        .load      (cnt_load),
        .load_data (ld_lo),
        .en        (tick),
        .q         (lo_q),
        .carry     (lo_carry)
    );

    cascade_timer_stage #(.M(M_HI), .W(NH)) u_hi (
        .clk       (clk),
        .aclr      (aclr),
        .clr       (cnt_clr),
        .load      (cnt_load),
        .load_data (ld_hi),
        .en        (lo_carry),
        .q         (hi_q),
        .carry     (hi_carry)
    );

endmodule

// File: tb/tb_cascade_timer_ctrl.sv
// Bench for cascade_timer_ctrl (M_LO=10, M_HI=6, TICK_DIV=4): vector table
// with scoreboard queue, plus an asynchronous reset sequence.
module tb_cascade_timer_ctrl;

    localparam int M_LO = 10;
    localparam int M_HI = 6;
    localparam int TD   = 4;

    logic       clk = 1'b0;
    logic       aclr = 1'b0;
    logic       start = 1'b0, stop = 1'b0, clear = 1'b0, load = 1'b0;
    logic [3:0] lo_data = '0, alarm_lo = '0;
    logic [2:0] hi_data = '0, alarm_hi = '0;
    logic [3:0] lo_q;
    logic [2:0] hi_q;
    logic       tick, wrap, running, alarm;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string name;
        bit    c, sp, st, ld;
        int    lod, hid, alo, ahi, n;
        int    elo, ehi;
        bit    er, ea, et, ew;
    } vec_t;

    typedef struct {
        string name;
        int    lo, hi;
        bit    r, a, t, w;
    } exp_t;

    vec_t vt[$];
    exp_t sb[$];

    cascade_timer_ctrl #(.M_LO(M_LO), .M_HI(M_HI), .TICK_DIV(TD)) u_dut (
        .clk      (clk),
        .aclr     (aclr),
        .start    (start),
        .stop     (stop),
        .clear    (clear),
        .load     (load),
        .lo_data  (lo_data),
        .hi_data  (hi_data),
        .alarm_lo (alarm_lo),
        .alarm_hi (alarm_hi),
        .lo_q     (lo_q),
        .hi_q     (hi_q),
        .tick     (tick),
        .wrap     (wrap),
        .running  (running),
        .alarm    (alarm)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input string nm, input bit c, sp, st, ld,
                       input int lod, hid, alo, ahi, n,
                       input int elo, ehi, input bit er, ea, et, ew);
        vec_t v;
        v.name = nm; v.c = c; v.sp = sp; v.st = st; v.ld = ld;
        v.lod = lod; v.hid = hid; v.alo = alo; v.ahi = ahi; v.n = n;
        v.elo = elo; v.ehi = ehi; v.er = er; v.ea = ea; v.et = et; v.ew = ew;
        vt.push_back(v);
    endtask

    initial begin
        exp_t e;
        // name clr stp sta ld lod hid alo ahi n | lo hi run alm tick wrap
        add("idle",        0,0,0,0, 0,0, 15,7, 1,  0,0, 0,0,0,0);
        add("load_sat",    0,0,0,1, 12,7, 15,7, 1, 9,5, 0,0,0,0);
        add("start",       0,0,1,0, 0,0, 15,7, 1,  9,5, 1,0,0,0);
        add("load_in_run", 0,0,0,1, 1,1, 15,7, 3,  9,5, 1,0,1,1);
        add("wrap",        0,0,0,0, 0,0, 15,7, 1,  0,0, 1,0,0,0);
        add("count1",      0,0,0,0, 0,0, 15,7, 4,  1,0, 1,0,0,0);
        add("stop",        0,1,0,0, 0,0, 15,7, 1,  1,0, 0,0,0,0);
        add("paused",      0,0,0,0, 0,0, 15,7, 10, 1,0, 0,0,0,0);
        add("resume",      0,0,1,0, 0,0, 15,7, 1,  1,0, 1,0,0,0);
        add("resume_p2",   0,0,0,0, 0,0, 15,7, 1,  1,0, 1,0,0,0);
        add("resume_tick", 0,0,0,0, 0,0, 15,7, 1,  1,0, 1,0,1,0);
        add("count2",      0,0,0,0, 0,0, 15,7, 1,  2,0, 1,0,0,0);
        add("clear_start", 1,0,1,0, 0,0, 15,7, 1,  0,0, 0,0,0,0);
        add("stp_sta_ld",  0,1,1,1, 5,1, 15,7, 1,  0,0, 0,0,0,0);
`ifdef CASCADE_TIMER_AUTO_RELOAD_EN
        add("rl_preset",   0,0,0,1, 2,0, 4,0, 1,   2,0, 0,0,0,0);
        add("rl_start",    0,0,1,0, 0,0, 4,0, 1,   2,0, 1,0,0,0);
        add("rl_t1",       0,0,0,0, 0,0, 4,0, 3,   2,0, 1,0,1,0);
        add("rl_c3",       0,0,0,0, 0,0, 4,0, 1,   3,0, 1,0,0,0);
        add("rl_t2",       0,0,0,0, 0,0, 4,0, 3,   3,0, 1,0,1,0);
        add("rl_match",    0,0,0,0, 0,0, 4,0, 1,   2,0, 1,1,0,0);
        add("rl_pulse",    0,0,0,0, 0,0, 4,0, 1,   2,0, 1,0,0,0);
        add("rl_t3",       0,0,0,0, 0,0, 4,0, 6,   3,0, 1,0,1,0);
        add("rl_match2",   0,0,0,0, 0,0, 4,0, 1,   2,0, 1,1,0,0);
`else
        add("al_start",    0,0,1,0, 0,0, 3,0, 1,   0,0, 1,0,0,0);
        add("al_t1",       0,0,0,0, 0,0, 3,0, 3,   0,0, 1,0,1,0);
        add("al_c1",       0,0,0,0, 0,0, 3,0, 1,   1,0, 1,0,0,0);
        add("al_c2",       0,0,0,0, 0,0, 3,0, 4,   2,0, 1,0,0,0);
        add("al_hit",      0,0,0,0, 0,0, 3,0, 4,   3,0, 0,1,0,0);
        add("al_hold",     0,0,0,0, 0,0, 3,0, 20,  3,0, 0,1,0,0);
        add("al_load_ign", 0,0,0,1, 7,0, 3,0, 1,   3,0, 0,1,0,0);
        add("al_resume",   0,0,1,0, 0,0, 3,0, 1,   3,0, 1,0,0,0);
        add("al_c4",       0,0,0,0, 0,0, 3,0, 4,   4,0, 1,0,0,0);
        add("al_stop",     0,1,0,0, 0,0, 3,0, 1,   4,0, 0,0,0,0);
        add("load_pause",  0,0,0,1, 8,2, 3,0, 1,   8,2, 0,0,0,0);
`endif

        #12;
        chk("rst_lo", lo_q, 0);
        chk("rst_hi", hi_q, 0);
        chk("rst_run", running, 0);
        chk("rst_alm", alarm, 0);
        chk("rst_tick", tick, 0);
        aclr = 1'b1;
        step();

        foreach (vt[i]) begin
            clear    = vt[i].c;
            stop     = vt[i].sp;
            start    = vt[i].st;
            load     = vt[i].ld;
            lo_data  = 4'(vt[i].lod);
            hi_data  = 3'(vt[i].hid);
            alarm_lo = 4'(vt[i].alo);
            alarm_hi = 3'(vt[i].ahi);
            sb.push_back('{vt[i].name, vt[i].elo, vt[i].ehi,
                           vt[i].er, vt[i].ea, vt[i].et, vt[i].ew});
            repeat (vt[i].n) step();
            e = sb.pop_front();
            chk({e.name, ".lo"}, lo_q, e.lo);
            chk({e.name, ".hi"}, hi_q, e.hi);
            chk({e.name, ".run"}, running, e.r);
            chk({e.name, ".alm"}, alarm, e.a);
            chk({e.name, ".tick"}, tick, e.t);
            chk({e.name, ".wrap"}, wrap, e.w);
        end

        // Asynchronous reset in the middle of a RUN cycle.
        start = 0; stop = 0; load = 0;
        alarm_lo = 4'd15; alarm_hi = 3'd7;
        clear = 1; step(); clear = 0;
        lo_data = 4'd5; hi_data = 3'd0;
        load = 1; step(); load = 0;
        start = 1; step(); start = 0;
        repeat (2) step();
        chk("mr_pre_lo", lo_q, 5);
        chk("mr_pre_run", running, 1);
        #3 aclr = 1'b0;
        #1;
        chk("mr_lo", lo_q, 0);
        chk("mr_hi", hi_q, 0);
        chk("mr_run", running, 0);
        chk("mr_alm", alarm, 0);
        #2 aclr = 1'b1;
        repeat (6) step();
        chk("mr_idle_run", running, 0);
        chk("mr_idle_lo", lo_q, 0);
        chk("mr_idle_tick", tick, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
